// File: rtl/never8_pkg.sv
// Shared Never8 core definitions: data width and write-arbiter FSM encoding.
package never8_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage : never8_pkg

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after last_grant+1, with wrap.
module rr_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    int unsigned idx;

    // Walk offsets from farthest to nearest so the nearest requesting index wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (32'(last_grant) + 32'(off)) % NUM_REQ;
            if (req[IDX_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end

endmodule : rr_picker

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the Never8 internal register write bus; one write per two cycles.
module reg_write_arbiter
    import never8_pkg::*;
#(
    parameter  int unsigned NUM_REQ  = 4,
    parameter  int unsigned ADDR_W   = 3,
    localparam int unsigned NUM_REGS = 1 << ADDR_W,
    localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [DATA_W-1:0]          bus_data,
    output logic [NUM_REGS-1:0]        reg_en,
    output logic                       busy,
    output logic [IDX_W-1:0]           last_grant
);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    // Mux the winner's address and data out of the packed request buses.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and registered-output logic: arbitrate in IDLE, release in HOLD.
    always_comb begin
        state_d      = state_q;
        ack_d        = '0;
        reg_en_d     = '0;
        busy_d       = 1'b0;
        bus_data_d   = bus_data_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = HOLD;
                    ack_d        = NUM_REQ'(1) << pick_idx;
                    reg_en_d     = NUM_REGS'(1) << sel_addr;
                    busy_d       = 1'b1;
                    bus_data_d   = sel_data;
                    last_grant_d = pick_idx;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ack_q        <= '0;
            reg_en_q     <= '0;
            busy_q       <= 1'b0;
            bus_data_q   <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            reg_en_q     <= reg_en_d;
            busy_q       <= busy_d;
            bus_data_q   <= bus_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ack        = ack_q;
    assign reg_en     = reg_en_q;
    assign busy       = busy_q;
    assign bus_data   = bus_data_q;
    assign last_grant = last_grant_q;

endmodule : reg_write_arbiter
